reg_writeback: RTL
==================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have no parameters; queue depth is fixed at 4 entries.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ResValid  input  1  producer offers a result this cycle.
REQ-005 ResAddr  input  4  destination register of offered result.
REQ-006 ResData  input  32  offered result value.
REQ-007 ResReady  output  1  block accepts a result this cycle.
REQ-008 Waddr  output  4  register-file write address, registered.
REQ-009 Writedata  output  32  register-file write data, registered.
REQ-010 RegWr  output  1  register-file write enable, registered; high for exactly one CLK cycle per retired entry.
REQ-011 Raddr1, Raddr2  input  4 each  register-file read addresses being issued by decode.
REQ-012 Hazard1, Hazard2  output  1 each  pending write exists for Raddr1 / Raddr2.
REQ-013 Count  output  3  number of entries queued (0..4), excluding the output stage.

Function
REQ-014 ResReady SHALL equal (Count < 4) and not RESET, derived combinationally from registered state only.
REQ-015 A push SHALL occur at a posedge where ResValid and ResReady are both 1; {ResAddr, ResData} is written at the tail.
REQ-016 At every posedge with Count != 0 the head entry SHALL be loaded into Waddr/Writedata, RegWr set to 1, and the head popped; with Count == 0 RegWr SHALL be set to 0 and Waddr/Writedata held.
REQ-017 Outputs SHALL be stable for the whole cycle so the register file samples them at the intervening negedge CLK.
REQ-018 Entries SHALL retire in strict acceptance order; writes to the same address are never merged or dropped.
REQ-019 Push and pop in the same cycle SHALL leave Count unchanged; when full (Count == 4), ResReady is 0 even if a pop occurs that cycle.
REQ-020 Pointers SHALL be 2-bit and wrap from 3 to 0; Count SHALL never exceed 4 nor underflow.
REQ-021 Minimum latency (no bypass): result accepted at posedge N -> RegWr = 1 during the cycle following posedge N+1.
REQ-022 Sustained throughput SHALL be one result per cycle.
REQ-023 HazardK SHALL be 1 when RaddrK equals the address of any queued valid entry, or equals Waddr while RegWr = 1; combinational; register 0 has no special treatment.
REQ-024 A result being pushed in the current cycle SHALL NOT contribute to Hazard1/Hazard2.

Reset
REQ-025 At a posedge with RESET = 1: Count = 0, pointers = 0, RegWr = 0, Waddr = 0, Writedata = 0; queued entries are discarded.
REQ-026 While RESET = 1, ResReady SHALL be 0 and no push SHALL occur; Hazard1/Hazard2 SHALL read 0 after the reset edge.
REQ-027 RESET asserted mid-stream SHALL take priority over any simultaneous push or pop.

Configuration
REQ-028 Macro WB_BYPASS_EN: when defined, a push at a posedge with Count == 0 SHALL load the result directly into Waddr/Writedata with RegWr = 1 in the next cycle (latency one cycle less), Count staying 0.
REQ-029 Without WB_BYPASS_EN, every result SHALL pass through the queue per REQ-021; all other requirements are identical in both builds.

Verification
REQ-030 Reset, then push {addr 3, 0x0000_00AA} once -> RegWr = 1 with Waddr = 3, Writedata = 0xAA for exactly one cycle, 2 cycles after push edge (1 with WB_BYPASS_EN).
REQ-031 With output stalled impossible, push 6 back-to-back results addr 1..6 -> RegWr high 6 consecutive cycles, addresses 1..6 in order, Count never above 1.
REQ-032 Push 5 results in one burst while RESET toggles off at first push -> Count reaches at most 4, ResReady = 0 exactly when Count = 4, no entry lost or duplicated across pointer wrap.
REQ-033 Queue holds addr 7; drive Raddr1 = 7, Raddr2 = 8 -> Hazard1 = 1, Hazard2 = 0; after RegWr cycle for addr 7 ends, Hazard1 = 0.
REQ-034 Two pushes to addr 5 with data 0x11 then 0x22 -> register file holds 0x22 afterward; both writes observed in order.
REQ-035 Assert RESET with 3 entries queued -> next cycle Count = 0, RegWr = 0, no further writes issued.

Source files
------------

// File: rtl/reg_writeback.sv
// Register-file writeback queue: 4-entry in-order FIFO feeding a registered write port.
// Define WB_BYPASS_EN to let a result offered while the queue is empty skip the queue.
module reg_writeback (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ResValid,
  input  logic [3:0]  ResAddr,
  input  logic [31:0] ResData,
  output logic        ResReady,
  output logic [3:0]  Waddr,
  output logic [31:0] Writedata,
  output logic        RegWr,
  input  logic [3:0]  Raddr1,
  input  logic [3:0]  Raddr2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic [2:0]  Count
);

  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t      mem_q [Depth];
  entry_t      mem_d [Depth];
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwr_q, regwr_d;

  logic push, pop, bypass, enq;

  assign ResReady = (count_q < 3'd4) && !RESET;
  assign push     = ResValid && ResReady;
  assign pop      = (count_q != 3'd0);

`ifdef WB_BYPASS_EN
  assign bypass = push && (count_q == 3'd0);
`else
  assign bypass = 1'b0;
`endif

  assign enq = push && !bypass;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    regwr_d = 1'b0;

    if (pop) begin
      waddr_d = mem_q[head_q].addr;
      wdata_d = mem_q[head_q].data;
      regwr_d = 1'b1;
      head_d  = head_q + 2'd1;
    end else if (bypass) begin
      waddr_d = ResAddr;
      wdata_d = ResData;
      regwr_d = 1'b1;
    end

    if (enq) begin
      mem_d[tail_q] = '{addr: ResAddr, data: ResData};
      tail_d        = tail_q + 2'd1;
    end

    unique case ({enq, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      waddr_q <= 4'd0;
      wdata_q <= 32'd0;
      regwr_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      regwr_q <= regwr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Only slots within count_q entries of the head are live.
  always_comb begin
    logic [1:0] idx;
    logic       live;
    Hazard1 = regwr_q && (waddr_q == Raddr1);
    Hazard2 = regwr_q && (waddr_q == Raddr2);
    for (int i = 0; i < Depth; i++) begin
      idx  = head_q + 2'(i);
      live = (3'(i) < count_q);
      if (live && (mem_q[idx].addr == Raddr1)) Hazard1 = 1'b1;
      if (live && (mem_q[idx].addr == Raddr2)) Hazard2 = 1'b1;
    end
  end

  assign Waddr     = waddr_q;
  assign Writedata = wdata_q;
  assign RegWr     = regwr_q;
  assign Count     = count_q;

endmodule
